// File: rtl/toy_pack.sv
// Shared icache types: MSHR entry layout, ICACHE_* widths and linefill receiver defaults.
package toy_pack;

  localparam int unsigned ICACHE_TAG_WIDTH       = 20;
  localparam int unsigned ICACHE_INDEX_WIDTH     = 6;
  localparam int unsigned ICACHE_OFFSET_WIDTH    = 6;
  localparam int unsigned ICACHE_REQ_TXNID_WIDTH = 5;

  localparam int unsigned LINEFILL_BEAT_NUM   = 4;
  localparam int unsigned LINEFILL_BEAT_WIDTH = 128;

  typedef enum logic [2:0] {
    MSHR_IDLE,
    SEND_DOWNSTREAM_REQ,
    WAIT_FILL_DONE,
    MSHR_RELEASE
  } state_t;

  typedef enum logic [1:0] {
    LfIdle,
    LfCollect,
    LfWrite,
    LfDone
  } lf_state_e;

  typedef struct packed {
    logic [ICACHE_TAG_WIDTH-1:0]    tag;
    logic [ICACHE_INDEX_WIDTH-1:0]  index;
    logic [ICACHE_OFFSET_WIDTH-1:0] offset;
  } icache_addr_t;

  typedef struct packed {
    icache_addr_t addr;
  } icache_req_pld_t;

  typedef struct packed {
    logic            valid;
    icache_req_pld_t req_pld;
    logic            dest_way;
  } mshr_entry_t;

  typedef struct packed {
    logic [ICACHE_REQ_TXNID_WIDTH-1:0]    txnid;
    logic [$clog2(LINEFILL_BEAT_NUM)-1:0] beat_id;
    logic [LINEFILL_BEAT_WIDTH-1:0]       data;
  } rxdat_pld_t;

endpackage

// File: rtl/icache_linefill_rx_line_buf.sv
// Beat register file for one cache line; a beat lands in the slot chosen by slot_i.
module icache_linefill_line_buf #(
  parameter int unsigned BeatNum   = 4,
  parameter int unsigned BeatWidth = 128,
  parameter int unsigned SlotW     = 2
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         clr_i,
  input  logic                         wr_en_i,
  input  logic [SlotW-1:0]             slot_i,
  input  logic [BeatWidth-1:0]         wdata_i,
  output logic [BeatNum*BeatWidth-1:0] line_o
);

  logic [BeatNum*BeatWidth-1:0] line_q;

  always_ff @(posedge clk_i) begin
    if (rst_i || clr_i) begin
      line_q <= '0;
    end else if (wr_en_i) begin
      for (int unsigned k = 0; k < BeatNum; k++) begin
        if (slot_i == SlotW'(k)) begin
          line_q[k*BeatWidth +: BeatWidth] <= wdata_i;
        end
      end
    end
  end

  assign line_o = line_q;

endmodule

// File: rtl/icache_linefill_rx.sv
// Collects downstream read beats into a line, writes it to the data RAM, then releases the MSHR.
// Optional protocol checking is enabled by defining ICACHE_LINEFILL_CHK_EN.
module icache_linefill_rx
  import toy_pack::*;
#(
  parameter int unsigned MSHR_ENTRY_NUM = 8,
  parameter int unsigned BEAT_NUM       = LINEFILL_BEAT_NUM,
  parameter int unsigned BEAT_WIDTH     = LINEFILL_BEAT_WIDTH,
  localparam int unsigned LINE_WIDTH    = BEAT_NUM * BEAT_WIDTH,
  localparam int unsigned BeatIdW       = (BEAT_NUM > 1) ? $clog2(BEAT_NUM) : 1,
  localparam int unsigned EntryW        = (MSHR_ENTRY_NUM > 1) ? $clog2(MSHR_ENTRY_NUM) : 1
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  downstream_rxdat_vld,
  output logic                                  downstream_rxdat_rdy,
  input  logic [ICACHE_REQ_TXNID_WIDTH-1:0]     downstream_rxdat_txnid,
  input  logic [BeatIdW-1:0]                    downstream_rxdat_beat_id,
  input  logic [BEAT_WIDTH-1:0]                 downstream_rxdat_data,
  input  mshr_entry_t [MSHR_ENTRY_NUM-1:0]      mshr_entry_array,
  output logic                                  dataram_wr_vld,
  input  logic                                  dataram_wr_rdy,
  output logic                                  dataram_wr_way,
  output logic [ICACHE_INDEX_WIDTH-1:0]         dataram_wr_index,
  output logic [LINE_WIDTH-1:0]                 dataram_wr_data,
  output logic [MSHR_ENTRY_NUM-1:0]             linefill_done,
  output logic                                  linefill_err
);

  lf_state_e                         state_q, state_d;
  logic [BeatIdW-1:0]                cnt_q, cnt_d;
  logic [ICACHE_REQ_TXNID_WIDTH-1:0] txnid_q, txnid_d;
  logic                              inv_q, inv_d;
  logic                              err_q, err_d;
  logic [EntryW-1:0]                 entry_q, rx_entry;
  logic                              beat_fire;
  logic                              last_beat;
  logic [LINE_WIDTH-1:0]             line;

  assign entry_q   = txnid_q[EntryW-1:0];
  assign rx_entry  = downstream_rxdat_txnid[EntryW-1:0];
  assign beat_fire = downstream_rxdat_vld & downstream_rxdat_rdy;
  assign last_beat = (cnt_q == BeatIdW'(BEAT_NUM - 1));

  always_comb begin
    state_d              = state_q;
    cnt_d                = cnt_q;
    txnid_d              = txnid_q;
    inv_d                = inv_q;
    downstream_rxdat_rdy = 1'b0;
    dataram_wr_vld       = 1'b0;
    linefill_done        = '0;
    unique case (state_q)
      LfIdle: begin
        downstream_rxdat_rdy = 1'b1;
        if (downstream_rxdat_vld) begin
          txnid_d = downstream_rxdat_txnid;
          inv_d   = ~mshr_entry_array[rx_entry].valid;
          if (BEAT_NUM == 1) begin
            state_d = inv_d ? LfDone : LfWrite;
          end else begin
            cnt_d   = BeatIdW'(1);
            state_d = LfCollect;
          end
        end
      end
      LfCollect: begin
        downstream_rxdat_rdy = 1'b1;
        if (downstream_rxdat_vld) begin
          if (last_beat) begin
            cnt_d   = '0;
            // An invalid owner gets no RAM write and no release pulse.
            state_d = inv_q ? LfDone : LfWrite;
          end else begin
            cnt_d = cnt_q + BeatIdW'(1);
          end
        end
      end
      LfWrite: begin
        dataram_wr_vld = 1'b1;
        if (dataram_wr_rdy) state_d = LfDone;
      end
      LfDone: begin
        linefill_done[entry_q] = ~inv_q;
        state_d                = LfIdle;
      end
      default: state_d = LfIdle;
    endcase
  end

`ifdef ICACHE_LINEFILL_CHK_EN
  always_comb begin
    err_d = beat_fire &&
            ((downstream_rxdat_beat_id != cnt_q) ||
             ((state_q == LfCollect) && (downstream_rxdat_txnid != txnid_q)) ||
             ((state_q == LfIdle) && !mshr_entry_array[rx_entry].valid));
  end
`else
  logic unused_beat_id;
  assign unused_beat_id = ^downstream_rxdat_beat_id;
  assign err_d          = 1'b0;
`endif

  logic unused_sig;
  assign unused_sig = ^{mshr_entry_array, txnid_q, downstream_rxdat_txnid};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= LfIdle;
      cnt_q   <= '0;
      txnid_q <= '0;
      inv_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      txnid_q <= txnid_d;
      inv_q   <= inv_d;
      err_q   <= err_d;
    end
  end

  icache_linefill_line_buf #(
    .BeatNum  (BEAT_NUM),
    .BeatWidth(BEAT_WIDTH),
    .SlotW    (BeatIdW)
  ) u_line_buf (
    .clk_i  (clk),
    .rst_i  (rst),
    .clr_i  (state_q == LfDone),
    .wr_en_i(beat_fire),
    .slot_i (cnt_q),
    .wdata_i(downstream_rxdat_data),
    .line_o (line)
  );

  assign dataram_wr_way   = dataram_wr_vld & mshr_entry_array[entry_q].dest_way;
  assign dataram_wr_index = dataram_wr_vld ? mshr_entry_array[entry_q].req_pld.addr.index : '0;
  assign dataram_wr_data  = dataram_wr_vld ? line : '0;
  assign linefill_err     = err_q;

endmodule

// File: tb/tb_icache_linefill_rx.sv
// Directed bench for icache_linefill_rx; error expectations follow ICACHE_LINEFILL_CHK_EN.
module tb_icache_linefill_rx;
  import toy_pack::*;

  localparam int unsigned N  = 8;
  localparam int unsigned BW = 128;
  localparam int unsigned LW = 512;
`ifdef ICACHE_LINEFILL_CHK_EN
  localparam logic ChkEn = 1'b1;
`else
  localparam logic ChkEn = 1'b0;
`endif

  logic                              clk = 1'b0;
  logic                              rst;
  logic                              vld;
  logic                              rdy;
  logic [ICACHE_REQ_TXNID_WIDTH-1:0] txnid;
  logic [1:0]                        beat_id;
  logic [BW-1:0]                     data;
  mshr_entry_t [N-1:0]               ents;
  logic                              wr_vld;
  logic                              wr_rdy;
  logic                              wr_way;
  logic [ICACHE_INDEX_WIDTH-1:0]     wr_index;
  logic [LW-1:0]                     wr_data;
  logic [N-1:0]                      done;
  logic                              err;

  int total = 0;
  int bad   = 0;
  int ndone = 0;
  int base;
  logic [N-1:0] done_log [16];

  always #5 clk = ~clk;

  icache_linefill_rx dut (
    .clk                     (clk),
    .rst                     (rst),
    .downstream_rxdat_vld    (vld),
    .downstream_rxdat_rdy    (rdy),
    .downstream_rxdat_txnid  (txnid),
    .downstream_rxdat_beat_id(beat_id),
    .downstream_rxdat_data   (data),
    .mshr_entry_array        (ents),
    .dataram_wr_vld          (wr_vld),
    .dataram_wr_rdy          (wr_rdy),
    .dataram_wr_way          (wr_way),
    .dataram_wr_index        (wr_index),
    .dataram_wr_data         (wr_data),
    .linefill_done           (done),
    .linefill_err            (err)
  );

  always @(posedge clk) begin
    if (done != '0) begin
      if (ndone < 16) done_log[ndone] <= done;
      ndone <= ndone + 1;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [LW-1:0] mkline(input logic [BW-1:0] b);
    return {b + 128'd3, b + 128'd2, b + 128'd1, b};
  endfunction

  task automatic set_ent(input int idx, input logic v, input logic [5:0] ix, input logic w);
    ents[idx].valid                  = v;
    ents[idx].req_pld.addr.index     = ix;
    ents[idx].dest_way               = w;
  endtask

  // Called at a negedge; holds vld until the beat is accepted, returns at the next negedge.
  task automatic send(input logic [4:0] t, input logic [1:0] id, input logic [BW-1:0] d);
    int n = 0;
    vld = 1'b1;
    txnid = t;
    beat_id = id;
    data = d;
    while (!rdy && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("beat_accept", rdy, 1'b1);
    @(negedge clk);
    vld = 1'b0;
  endtask

  task automatic send_line(input logic [4:0] t, input logic [BW-1:0] b);
    for (int i = 0; i < 4; i++) send(t, 2'(i), b + BW'(i));
  endtask

  task automatic check_write(input string tag, input logic [5:0] ix, input logic w,
                             input logic [BW-1:0] b);
    chk({tag, "_wr_vld"}, wr_vld, 1'b1);
    chk({tag, "_index"}, wr_index, ix);
    chk({tag, "_way"}, wr_way, w);
    chk({tag, "_data"}, wr_data, mkline(b));
    chk({tag, "_rdy_low"}, rdy, 1'b0);
  endtask

  initial begin
    rst = 1'b1; vld = 1'b0; txnid = '0; beat_id = '0; data = '0; wr_rdy = 1'b1; ents = '0;
    set_ent(1, 1'b1, 6'h01, 1'b0);
    set_ent(2, 1'b1, 6'h05, 1'b0);
    set_ent(3, 1'b1, 6'h12, 1'b1);
    set_ent(4, 1'b1, 6'h2A, 1'b1);
    set_ent(6, 1'b1, 6'h3F, 1'b1);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_rdy", rdy, 1'b1);
    chk("rst_wr_vld", wr_vld, 1'b0);
    chk("rst_done", done, '0);
    chk("rst_err", err, 1'b0);
    chk("rst_data", wr_data, '0);

    // Single line, back-to-back beats
    send_line(5'd3, 128'hA0);
    check_write("single", 6'h12, 1'b1, 128'hA0);
    @(negedge clk);
    chk("single_done", done, 8'b0000_1000);
    chk("single_wr_vld_off", wr_vld, 1'b0);
    chk("single_done_rdy", rdy, 1'b0);
    @(negedge clk);
    chk("single_idle_rdy", rdy, 1'b1);
    chk("single_done_off", done, '0);

    // Write backpressure
    wr_rdy = 1'b0;
    send_line(5'd2, 128'hB0);
    for (int i = 0; i < 5; i++) begin
      check_write("bp", 6'h05, 1'b0, 128'hB0);
      chk("bp_no_done", done, '0);
      @(negedge clk);
    end
    wr_rdy = 1'b1;
    check_write("bp_hs", 6'h05, 1'b0, 128'hB0);
    @(negedge clk);
    chk("bp_done", done, 8'b0000_0100);
    @(negedge clk);
    chk("bp_idle_rdy", rdy, 1'b1);

    // Gapped beats
    for (int i = 0; i < 4; i++) begin
      send(5'd4, 2'(i), 128'hC0 + BW'(i));
      if (i < 3) begin
        repeat (3) begin
          chk("gap_no_write", wr_vld, 1'b0);
          chk("gap_rdy", rdy, 1'b1);
          @(negedge clk);
        end
      end
    end
    check_write("gap", 6'h2A, 1'b1, 128'hC0);
    @(negedge clk);
    chk("gap_done", done, 8'b0001_0000);
    @(negedge clk);

    // Back-to-back lines; the second line's first beat waits out WRITE/DONE
    base = ndone;
    send_line(5'd1, 128'hD0);
    check_write("b2b1", 6'h01, 1'b0, 128'hD0);
    send_line(5'd6, 128'hE0);
    check_write("b2b2", 6'h3F, 1'b1, 128'hE0);
    @(negedge clk);
    @(negedge clk);
    chk("b2b_ndone", ndone - base, 2);
    chk("b2b_done0", done_log[base], 8'b0000_0010);
    chk("b2b_done1", done_log[base+1], 8'b0100_0000);

    // Invalid owner entry
    base = ndone;
    send(5'd5, 2'd0, 128'hF0);
    chk("inv_err", err, ChkEn);
    for (int i = 1; i < 4; i++) begin
      send(5'd5, 2'(i), 128'hF0 + BW'(i));
      chk("inv_err_quiet", err, 1'b0);
      chk("inv_no_write", wr_vld, 1'b0);
    end
    chk("inv_no_done", done, '0);
    @(negedge clk);
    chk("inv_idle_rdy", rdy, 1'b1);
    chk("inv_ndone", ndone - base, 0);

    // Out-of-order beat ids: stored by arrival order, flagged when checking
    send(5'd3, 2'd0, 128'h10);
    chk("ord_err0", err, 1'b0);
    send(5'd3, 2'd2, 128'h11);
    chk("ord_err1", err, ChkEn);
    send(5'd3, 2'd1, 128'h12);
    chk("ord_err2", err, ChkEn);
    send(5'd3, 2'd3, 128'h13);
    chk("ord_err3", err, 1'b0);
    check_write("ord", 6'h12, 1'b1, 128'h10);
    @(negedge clk);
    chk("ord_done", done, 8'b0000_1000);
    @(negedge clk);

    // Reset mid-collect discards the partial line
    base = ndone;
    send(5'd2, 2'd0, 128'h20);
    send(5'd2, 2'd1, 128'h21);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mrst_rdy", rdy, 1'b1);
    chk("mrst_wr_vld", wr_vld, 1'b0);
    @(negedge clk);
    chk("mrst_no_done", done, '0);
    send_line(5'd2, 128'h30);
    check_write("mrst", 6'h05, 1'b0, 128'h30);
    @(negedge clk);
    chk("mrst_done", done, 8'b0000_0100);
    @(negedge clk);
    chk("mrst_ndone", ndone - base, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
